// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch stage for the RV64 datapath.
// Holds the PC, issues one word read at a time to instruction memory,
// captures the returned word into the instruction register (IR) together
// with a pre-decoded immediate-select code, and hands it downstream with a
// valid/ready handshake. Redirects, misaligned targets and memory timeouts
// are handled here; the last two are reported through sticky flags.
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        pc_load,
  input  logic [63:0] pc_target,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic [3:0]  imm_sel,
  output logic        instr_valid,
  input  logic        dec_ready,
  output logic        illegal_op,
  output logic        misaligned,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    FULL,
    HALT
  } state_t;

  typedef struct packed {
    logic       illegal;
    logic [3:0] sel;
  } predecode_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // The counter only has to reach MEM_TIMEOUT-1: the cycle that would make
  // it MEM_TIMEOUT is the one that raises fetch_err instead.
  localparam int          CW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state;
  logic [63:0]   pc;
  logic [CW-1:0] tmo_cnt;
  logic          drop;

  logic [63:0]   target_aligned;
  predecode_t    rdata_dec;

  // Map the opcode field onto the immediate-select code used by the
  // immediate generator; anything outside the supported set is flagged.
  function automatic predecode_t predecode(input logic [6:0] opcode);
    predecode_t d;
    d.illegal = 1'b0;
    d.sel     = 4'd0;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111: d.sel = 4'd1;
      7'b1100011:                         d.sel = 4'd2;
      7'b0110111:                         d.sel = 4'd3;
      7'b0100011:                         d.sel = 4'd4;
      7'b0110011, 7'b0111011:             d.sel = 4'd0;
      default:                            d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  // Redirect targets are always word aligned; low bits are reported, not used.
  assign target_aligned = {pc_target[63:2], 2'b00};
  assign rdata_dec      = predecode(mem_rdata[6:0]);

  // Fetch FSM with all outputs registered in the same block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      tmo_cnt     <= '0;
      drop        <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= 64'd0;
      instr       <= NOP;
      instr_pc    <= 64'd0;
      imm_sel     <= 4'd0;
      instr_valid <= 1'b0;
      illegal_op  <= 1'b0;
      misaligned  <= 1'b0;
      fetch_err   <= 1'b0;
    end else if (pc_load && state != HALT) begin
      // NOTE: non-blocking assignments throughout, so every decision in this
      // block sees the register values from before the clock edge.
      state       <= REQ;
      pc          <= target_aligned;
      mem_addr    <= target_aligned;
      mem_req     <= 1'b1;
      instr_valid <= 1'b0;
      tmo_cnt     <= '0;
      if (pc_target[1:0] != 2'b00) misaligned <= 1'b1;
      // A response still owed by memory belongs to the old path and must be
      // thrown away when it finally arrives.
      if (state == WAIT)                drop <= drop | ~mem_rvalid;
      else if (state == REQ && mem_gnt) drop <= 1'b1;
      else if (mem_rvalid)              drop <= 1'b0;
    end else begin
      // A stale response consumes the drop flag wherever it lands.
      if (mem_rvalid && drop) drop <= 1'b0;
      case (state)
        IDLE: begin
          state    <= REQ;
          mem_req  <= 1'b1;
          mem_addr <= pc;
        end
        REQ: begin
          if (mem_gnt) begin
            state   <= WAIT;
            mem_req <= 1'b0;
            tmo_cnt <= '0;
          end
        end
        WAIT: begin
          if (mem_rvalid && !drop) begin
            state       <= FULL;
            instr       <= mem_rdata;
            instr_pc    <= pc;
            imm_sel     <= rdata_dec.sel;
            illegal_op  <= rdata_dec.illegal;
            instr_valid <= 1'b1;
            pc          <= pc + 64'd4;
            tmo_cnt     <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= HALT;
            fetch_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        FULL: begin
          // No prefetch: the next request goes out only after consumption.
          if (dec_ready) begin
            state       <= REQ;
            instr_valid <= 1'b0;
            mem_req     <= 1'b1;
            mem_addr    <= pc;
          end
        end
        HALT: begin
          mem_req     <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A transaction-level model keeps
// the expected PC and derives the expected IR contents and pre-decode from
// the instruction word; memory responses are generated with random delays.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        pc_load;
  logic [63:0] pc_target;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic [3:0]  imm_sel;
  logic        instr_valid;
  logic        dec_ready;
  logic        illegal_op;
  logic        misaligned;
  logic        fetch_err;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [63:0] exp_pc;

  instr_fetch_unit #(.RESET_PC(64'h0), .MEM_TIMEOUT(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .imm_sel    (imm_sel),
    .instr_valid(instr_valid),
    .dec_ready  (dec_ready),
    .illegal_op (illegal_op),
    .misaligned (misaligned),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  // Reference pre-decode: returns {illegal, imm_sel}.
  function automatic logic [4:0] ref_decode(input logic [31:0] w);
    case (w[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: return 5'b0_0001;
      7'b1100011:                         return 5'b0_0010;
      7'b0110111:                         return 5'b0_0011;
      7'b0100011:                         return 5'b0_0100;
      7'b0110011, 7'b0111011:             return 5'b0_0000;
      default:                            return 5'b1_0000;
    endcase
  endfunction

  function automatic logic [31:0] rand_word();
    logic [6:0]  ops [10];
    logic [31:0] r;
    ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1100011, 7'b0110111,
            7'b0100011, 7'b0110011, 7'b0111011, 7'b1111111, 7'b0001111};
    r = $urandom;
    return {r[31:7], ops[$urandom_range(0, 9)]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    mem_gnt   = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    pc_load   = 1'b0;
    pc_target = 64'h0;
    dec_ready = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({mem_req, mem_addr, instr, instr_pc, imm_sel, instr_valid, illegal_op, misaligned, fetch_err}
        !== {1'b0, 64'd0, 32'h13, 64'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_values: req=%b addr=%h instr=%h ipc=%h sel=%h v=%b ill=%b mis=%b err=%b, expected all zero with instr=00000013",
               mem_req, mem_addr, instr, instr_pc, imm_sel, instr_valid, illegal_op, misaligned, fetch_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_pc  = 64'h0;
  endtask

  // Waits for the request, grants it, optionally returns a stale word first,
  // then returns w and checks the captured instruction.
  task automatic fetch(input logic [31:0] w, input int gnt_dly, input int rv_dly, input bit stale);
    int         n;
    logic [4:0] d;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== exp_pc) begin
      tests_failed++;
      $display("FAIL fetch_request: req=%b addr=%h, expected req=1 addr=%h", mem_req, mem_addr, exp_pc);
    end
    repeat (gnt_dly) begin
      dec_ready = 1'($urandom);
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tests_run++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wait_state: req=%b valid=%b, expected req=0 valid=0", mem_req, instr_valid);
    end
    if (stale) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEADBEEF;
      tick();
      mem_rvalid = 1'b0;
      tests_run++;
      if (instr_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL stale_drop: valid=%b instr=%h, expected stale word discarded", instr_valid, instr);
      end
    end
    repeat (rv_dly) begin
      dec_ready = 1'($urandom);
      tick();
    end
    dec_ready  = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = w;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    d = ref_decode(w);
    tests_run++;
    if ({instr_valid, instr, instr_pc, imm_sel, illegal_op} !== {1'b1, w, exp_pc, d[3:0], d[4]}) begin
      tests_failed++;
      $display("FAIL capture: v=%b instr=%h ipc=%h sel=%h ill=%b, expected v=1 instr=%h ipc=%h sel=%h ill=%b",
               instr_valid, instr, instr_pc, imm_sel, illegal_op, w, exp_pc, d[3:0], d[4]);
    end
    exp_pc = exp_pc + 64'd4;
  endtask

  // Holds the IR for some cycles, then consumes it and checks the next request.
  task automatic consume(input int hold, input logic [31:0] w);
    for (int i = 0; i < hold; i++) begin
      tick();
      tests_run++;
      if (mem_req !== 1'b0 || instr_valid !== 1'b1 || instr !== w) begin
        tests_failed++;
        $display("FAIL hold: req=%b valid=%b instr=%h, expected req=0 valid=1 instr=%h", mem_req, instr_valid, instr, w);
      end
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    tests_run++;
    if (mem_req !== 1'b1 || instr_valid !== 1'b0 || mem_addr !== exp_pc || instr !== w) begin
      tests_failed++;
      $display("FAIL consume: req=%b valid=%b addr=%h instr=%h, expected req=1 valid=0 addr=%h instr=%h",
               mem_req, instr_valid, mem_addr, instr, exp_pc, w);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tick();  // IDLE -> REQ edge
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== 64'd0) begin
      tests_failed++;
      $display("FAIL first_request: req=%b addr=%h, expected req=1 addr=0", mem_req, mem_addr);
    end
  endtask

  task automatic test_first_fetch();
    fetch(32'hFFF00093, 0, 0, 1'b0);
    consume(0, 32'hFFF00093);
  endtask

  task automatic test_sequential();
    logic [31:0] words [3];
    words = '{32'h00500063, 32'h123450B7, 32'h00112023};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      fetch(words[i], 0, 1, 1'b0);
      consume(0, words[i]);
    end
  endtask

  task automatic test_stall();
    logic [31:0] w;
    w = rand_word();
    fetch(w, 0, 0, 1'b0);
    consume(5, w);
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int i = 0; i < 24; i++) begin
      w = rand_word();
      fetch(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), 1'b0);
      consume(int'($urandom_range(0, 3)), w);
    end
  endtask

  task automatic test_redirect_wait();
    logic [31:0] w;
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== exp_pc) begin
      tests_failed++;
      $display("FAIL redirect_setup: req=%b addr=%h, expected req=1 addr=%h", mem_req, mem_addr, exp_pc);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt   = 1'b0;
    tick();
    pc_load   = 1'b1;
    pc_target = 64'h100;
    tick();
    pc_load   = 1'b0;
    tests_run++;
    if ({mem_req, mem_addr, instr_valid, misaligned} !== {1'b1, 64'h100, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL redirect_wait: req=%b addr=%h valid=%b mis=%b, expected req=1 addr=100 valid=0 mis=0",
               mem_req, mem_addr, instr_valid, misaligned);
    end
    exp_pc = 64'h100;
    w = rand_word();
    fetch(w, 0, int'($urandom_range(0, 2)), 1'b1);
    consume(0, w);
  endtask

  task automatic test_misaligned_priority();
    logic [31:0] w;
    w = rand_word();
    fetch(w, 0, 0, 1'b0);
    pc_load   = 1'b1;
    pc_target = 64'h102;
    dec_ready = 1'b1;
    tick();
    pc_load   = 1'b0;
    dec_ready = 1'b0;
    tests_run++;
    if ({misaligned, mem_req, mem_addr, instr_valid, instr} !== {1'b1, 1'b1, 64'h100, 1'b0, w}) begin
      tests_failed++;
      $display("FAIL misaligned_redirect: mis=%b req=%b addr=%h valid=%b instr=%h, expected mis=1 req=1 addr=100 valid=0 instr=%h",
               misaligned, mem_req, mem_addr, instr_valid, instr, w);
    end
    exp_pc = 64'h100;
    fetch(32'h0000007F, 1, 0, 1'b0);
    consume(1, 32'h0000007F);
  endtask

  task automatic test_wrap();
    logic [31:0] w;
    w = rand_word();
    fetch(w, 0, 0, 1'b0);
    pc_load   = 1'b1;
    pc_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    pc_load   = 1'b0;
    exp_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    w = rand_word();
    fetch(w, 0, 0, 1'b0);
    consume(0, w);  // expects next address 0 after wrap
  endtask

  task automatic test_timeout();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    repeat (15) tick();
    tests_run++;
    if (fetch_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_early: fetch_err=%b after 15 wait cycles, expected 0", fetch_err);
    end
    tick();
    tests_run++;
    if ({fetch_err, mem_req, instr_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL timeout: err=%b req=%b valid=%b, expected err=1 req=0 valid=0", fetch_err, mem_req, instr_valid);
    end
    pc_load   = 1'b1;
    pc_target = 64'h40;
    mem_gnt   = 1'b1;
    dec_ready = 1'b1;
    repeat (3) tick();
    pc_load   = 1'b0;
    mem_gnt   = 1'b0;
    dec_ready = 1'b0;
    tests_run++;
    if ({fetch_err, mem_req, instr_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL halt_sticky: err=%b req=%b valid=%b, expected err=1 req=0 valid=0", fetch_err, mem_req, instr_valid);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    tick();
    pc_load   = 1'b1;
    pc_target = 64'h206;
    tick();
    pc_load   = 1'b0;
    exp_pc    = 64'h204;
    fetch(32'h00000013, 0, 0, 1'b0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    repeat (2) tick();
    tests_run++;
    if (misaligned !== 1'b1 || instr_valid !== 1'b1 || instr_pc !== 64'h204) begin
      tests_failed++;
      $display("FAIL pre_async_reset: mis=%b valid=%b ipc=%h, expected mis=1 valid=1 ipc=204", misaligned, instr_valid, instr_pc);
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    mem_gnt   = 1'b1;
    tick();
    mem_gnt   = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({mem_req, mem_addr, instr, instr_pc, imm_sel, instr_valid, illegal_op, misaligned, fetch_err}
        !== {1'b0, 64'd0, 32'h13, 64'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_reset: req=%b addr=%h instr=%h ipc=%h sel=%h v=%b ill=%b mis=%b err=%b, expected reset values",
               mem_req, mem_addr, instr, instr_pc, imm_sel, instr_valid, illegal_op, misaligned, fetch_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_stall();
    test_random();
    test_redirect_wait();
    test_misaligned_priority();
    test_wrap();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Multicycle fetch stage for the RV64 datapath. Holds the PC and issues word reads to instruction memory.
- Captures each returned 32-bit instruction into an instruction register (IR) and pre-decodes the opcode into the 4-bit immediate-select code.
- Drives the immediate generator and the decode/control logic directly downstream, with a valid/ready handshake toward them.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- MEM_TIMEOUT, 16, max cycles to wait for mem_rvalid before flagging fetch_err.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- mem_req  output  1  instruction memory read request
- mem_addr  output  64  read address (= PC at issue)
- mem_gnt  input  1  memory accepts request this cycle
- mem_rvalid  input  1  mem_rdata valid this cycle
- mem_rdata  input  32  instruction word
- pc_load  input  1  redirect (branch/jump taken)
- pc_target  input  64  redirect address
- instr  output  32  IR contents
- instr_pc  output  64  PC of instruction in IR
- imm_sel  output  4  immediate-select code
- instr_valid  output  1  IR holds an unconsumed instruction
- dec_ready  input  1  downstream consumes IR this cycle
- illegal_op  output  1  IR opcode not in supported set
- misaligned  output  1  pc_target[1:0] != 0 on redirect (sticky until reset)
- fetch_err  output  1  MEM_TIMEOUT expired (sticky until reset)

Behaviour:
- Reset (async assert, sync release): PC=RESET_PC, state=IDLE, mem_req=0, mem_addr=0, instr=32'h00000013 (NOP), instr_pc=0, imm_sel=0, instr_valid=0, illegal_op=0, misaligned=0, fetch_err=0, timeout counter=0.
- FSM states:
  - IDLE -> REQ: unconditionally on the first cycle after reset release.
  - REQ: mem_req=1, mem_addr=PC. On mem_gnt -> WAIT.
  - WAIT: mem_req=0. On mem_rvalid: IR<=mem_rdata, instr_pc<=PC, PC<=PC+4, instr_valid<=1 -> FULL. Counter increments each WAIT cycle; reaching MEM_TIMEOUT sets fetch_err -> HALT.
  - FULL: hold IR stable. On dec_ready: instr_valid<=0 -> REQ next cycle (one-cycle bubble; no prefetch).
  - HALT: mem_req=0, instr_valid=0; exit only via reset.
- Latency: REQ with same-cycle grant and rvalid one cycle after grant gives instr_valid 2 cycles after entering REQ.
- Pre-decode (registered with IR, on opcode = instr[6:0]):
  - 0010011, 0000011, 1100111 -> 1 (I-type)
  - 1100011 -> 2 (B-type)
  - 0110111 -> 3 (U-type LUI)
  - 0100011 -> 4 (S-type)
  - 0110011, 0111011 -> 0 (R-type)
  - any other opcode -> 0 with illegal_op=1
  - illegal_op is registered alongside IR.
- Redirect (pc_load=1, any state except HALT): PC<=pc_target; instr_valid<=0; state -> REQ.
  - If in WAIT, the pending response is dropped: the next mem_rvalid is discarded, tracked by a 1-bit drop flag.
  - pc_load has priority over dec_ready and mem_rvalid in the same cycle.
  - pc_target[1:0]!=0 sets misaligned; the PC is still loaded with bits [1:0] forced to 0.
- PC arithmetic: 64-bit, wraps 64'hFFFF_FFFF_FFFF_FFFC -> 0 with no flag.
- Outputs instr, instr_pc, imm_sel and illegal_op change only when IR is loaded. They are stable while instr_valid=1.
- dec_ready while instr_valid=0 is ignored.

Test Plan:
- Reset release, mem_gnt=1, rvalid one cycle later, rdata=32'hFFF00093 (addi x1,x0,-1) -> instr_valid=1 with instr=32'hFFF00093, imm_sel=1, instr_pc=0; next mem_addr=4.
- Sequential fetch of 0x00500063 (beq), 0x123450B7 (lui), 0x00112023 (sw) -> imm_sel 2, 3, 4; mem_addr 0, 4, 8.
- Hold dec_ready=0 for 5 cycles in FULL -> no mem_req, IR unchanged; dec_ready=1 -> mem_req the next cycle.
- pc_load with pc_target=64'h100 during WAIT, stale rvalid data 0xDEADBEEF -> stale word dropped, next mem_addr=64'h100, IR gets the new word.
- pc_target=64'h102 -> misaligned=1, mem_addr=64'h100. rdata=32'h0000007F -> illegal_op=1, imm_sel=0.
- Withhold mem_rvalid for 16 cycles -> fetch_err=1, HALT, mem_req=0. Assert reset_n=0 mid-WAIT -> all outputs return to reset values immediately.
